pipeline_stall_ctrl: RTL and testbench

//  Central pipeline scheduler. Merges ID stall request, load-use hazard, EX multicycle (mult/div) occupancy and flush request.

---
 rtl/pipeline_stall_ctrl_if.sv | 44 ++++
 rtl/pipeline_stall_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the ID/EX stages and the pipeline stall controller.
// Optional perf counter signals exist only when STALL_CTRL_PERF_EN is defined.
interface pipeline_stall_ctrl_if;
  logic       id_stallreq;
  logic       id_r1_en;
  logic [4:0] id_r1_addr;
  logic       id_r2_en;
  logic [4:0] id_r2_addr;
  logic       ex_is_load;
  logic       ex_wreg_en;
  logic [4:0] ex_wreg_addr;
  logic       ex_mc_start;
  logic       flush_req;
  logic [5:0] stall;
  logic       flush;
  logic       mc_busy;
  logic       mc_done;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_load_use;

  modport master (
    output id_stallreq, id_r1_en, id_r1_addr, id_r2_en, id_r2_addr,
    output ex_is_load, ex_wreg_en, ex_wreg_addr, ex_mc_start, flush_req,
    input  stall, flush, mc_busy, mc_done, perf_stall, perf_load_use
  );
  modport slave (
    input  id_stallreq, id_r1_en, id_r1_addr, id_r2_en, id_r2_addr,
    input  ex_is_load, ex_wreg_en, ex_wreg_addr, ex_mc_start, flush_req,
    output stall, flush, mc_busy, mc_done, perf_stall, perf_load_use
  );
`else
  modport master (
    output id_stallreq, id_r1_en, id_r1_addr, id_r2_en, id_r2_addr,
    output ex_is_load, ex_wreg_en, ex_wreg_addr, ex_mc_start, flush_req,
    input  stall, flush, mc_busy, mc_done
  );
  modport slave (
    input  id_stallreq, id_r1_en, id_r1_addr, id_r2_en, id_r2_addr,
    input  ex_is_load, ex_wreg_en, ex_wreg_addr, ex_mc_start, flush_req,
    output stall, flush, mc_busy, mc_done
  );
`endif
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline scheduler: merges flush, multicycle EX occupancy, load-use and ID stalls.
// Define STALL_CTRL_PERF_EN to add the perf_stall / perf_load_use counters.
module pipeline_stall_ctrl #(
  parameter int MC_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  pipeline_stall_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MC_LATENCY + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MC_BUSY = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       stall_comb;
  logic             flush_comb, busy_comb, done_comb;
  logic             load_use, lu_issue;

  assign load_use = bus.ex_is_load & bus.ex_wreg_en & (bus.ex_wreg_addr != 5'd0) &
                    ((bus.id_r1_en & (bus.id_r1_addr == bus.ex_wreg_addr)) |
                     (bus.id_r2_en & (bus.id_r2_addr == bus.ex_wreg_addr)));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_comb = STALL_NONE;
    flush_comb = 1'b0;
    busy_comb  = 1'b0;
    done_comb  = 1'b0;
    lu_issue   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_next = ST_FLUSH;
        end else if (bus.ex_mc_start) begin
          stall_comb = STALL_EX;
          busy_comb  = 1'b1;
          cnt_next   = CNT_W'(MC_LATENCY - 1);
          state_next = ST_MC_BUSY;
        end else if (load_use | bus.id_stallreq) begin
          stall_comb = STALL_ID;
          lu_issue   = load_use;
        end
      end
      ST_MC_BUSY: begin
        busy_comb = 1'b1;
        // A flush aborts the op outright; the result is never committed.
        if (bus.flush_req) begin
          cnt_next   = '0;
          state_next = ST_FLUSH;
        end else if (cnt_reg != '0) begin
          stall_comb = STALL_EX;
          cnt_next   = cnt_reg - CNT_W'(1);
        end else begin
          done_comb  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_comb = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Outputs are held low while reset is asserted, even if requests are active.
  assign bus.stall   = rst ? stall_comb : STALL_NONE;
  assign bus.flush   = rst & flush_comb;
  assign bus.mc_busy = rst & busy_comb;
  assign bus.mc_done = rst & done_comb;

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_reg, perf_load_use_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_reg    <= '0;
      perf_load_use_reg <= '0;
    end else begin
      if (stall_comb[0]) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (lu_issue)      perf_load_use_reg <= perf_load_use_reg + 32'd1;
    end
  end

  assign bus.perf_stall    = perf_stall_reg;
  assign bus.perf_load_use = perf_load_use_reg;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MC_LATENCY=32).
// Perf counter checks are compiled in only when STALL_CTRL_PERF_EN is defined.
module tb_pipeline_stall_ctrl;
  localparam int LAT = 32;
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipeline_stall_ctrl_if bus();

  pipeline_stall_ctrl #(.MC_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    bus.id_stallreq  = 1'b0;
    bus.id_r1_en     = 1'b0;
    bus.id_r1_addr   = 5'd0;
    bus.id_r2_en     = 1'b0;
    bus.id_r2_addr   = 5'd0;
    bus.ex_is_load   = 1'b0;
    bus.ex_wreg_en   = 1'b0;
    bus.ex_wreg_addr = 5'd0;
    bus.ex_mc_start  = 1'b0;
    bus.flush_req    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_load(input logic [4:0] ex_rd, input logic r1_en, input logic [4:0] r1,
                          input logic r2_en, input logic [4:0] r2);
    bus.ex_is_load   = 1'b1;
    bus.ex_wreg_en   = 1'b1;
    bus.ex_wreg_addr = ex_rd;
    bus.id_r1_en     = r1_en;
    bus.id_r1_addr   = r1;
    bus.id_r2_en     = r2_en;
    bus.id_r2_addr   = r2;
  endtask

  // Start a multicycle op and follow it to completion; optionally inject ignored requests.
  task automatic mc_op(input string tag, input bit inject);
    step();
    bus.ex_mc_start = 1'b1;
    #1;
    check({tag, "_t0_stall"}, 32'(bus.stall), 32'(S_EX));
    check({tag, "_t0_busy"}, 32'(bus.mc_busy), 32'd1);
    for (int i = 1; i < LAT; i++) begin
      step();
      if (inject && i == 5) begin
        set_load(5'd3, 1'b1, 5'd3, 1'b0, 5'd0);
        bus.id_stallreq = 1'b1;
        bus.ex_mc_start = 1'b1;
      end
      #1;
      check($sformatf("%s_t%0d_stall", tag, i), 32'(bus.stall), 32'(S_EX));
      if (i == LAT / 2) begin
        check({tag, "_mid_busy"}, 32'(bus.mc_busy), 32'd1);
        check({tag, "_mid_done"}, 32'(bus.mc_done), 32'd0);
      end
    end
    step();
    #1;
    check({tag, "_end_stall"}, 32'(bus.stall), 32'(S_NONE));
    check({tag, "_end_done"}, 32'(bus.mc_done), 32'd1);
    check({tag, "_end_busy"}, 32'(bus.mc_busy), 32'd1);
    step();
    #1;
    check({tag, "_idle_done"}, 32'(bus.mc_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.mc_busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    clear_inputs();
    #12;
    check("rst_stall", 32'(bus.stall), 32'(S_NONE));
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_busy", 32'(bus.mc_busy), 32'd0);
    check("rst_done", 32'(bus.mc_done), 32'd0);
`ifdef STALL_CTRL_PERF_EN
    check("rst_perf_stall", bus.perf_stall, 32'd0);
    check("rst_perf_lu", bus.perf_load_use, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Load-use hazards
    step(); set_load(5'd5, 1'b1, 5'd5, 1'b0, 5'd0); #1;
    check("lu_r1_stall", 32'(bus.stall), 32'(S_ID));
    step(); #1;
    check("lu_r1_release", 32'(bus.stall), 32'(S_NONE));
    step(); set_load(5'd0, 1'b1, 5'd0, 1'b1, 5'd0); #1;
    check("lu_r0_nostall", 32'(bus.stall), 32'(S_NONE));
    step(); set_load(5'd7, 1'b1, 5'd2, 1'b1, 5'd7); #1;
    check("lu_r2_stall", 32'(bus.stall), 32'(S_ID));
    step(); set_load(5'd7, 1'b1, 5'd2, 1'b0, 5'd7); #1;
    check("lu_r2_disabled", 32'(bus.stall), 32'(S_NONE));
    step(); set_load(5'd9, 1'b1, 5'd9, 1'b0, 5'd0); bus.ex_is_load = 1'b0; #1;
    check("lu_not_load", 32'(bus.stall), 32'(S_NONE));
    step(); bus.id_stallreq = 1'b1; #1;
    check("id_stallreq", 32'(bus.stall), 32'(S_ID));
    check("id_stallreq_busy", 32'(bus.mc_busy), 32'd0);

    // Full multicycle op with ignored requests mid-way
    mc_op("mc", 1'b1);

    // Flush aborts MC_BUSY in its 10th cycle
    step(); bus.ex_mc_start = 1'b1; #1;
    check("abort_start_busy", 32'(bus.mc_busy), 32'd1);
    for (int k = 1; k < 10; k++) step();
    step(); bus.flush_req = 1'b1; #1;
    check("abort_req_stall", 32'(bus.stall), 32'(S_NONE));
    check("abort_req_flush", 32'(bus.flush), 32'd0);
    step(); #1;
    check("abort_flush", 32'(bus.flush), 32'd1);
    check("abort_busy", 32'(bus.mc_busy), 32'd0);
    check("abort_done", 32'(bus.mc_done), 32'd0);
    check("abort_stall", 32'(bus.stall), 32'(S_NONE));
    step(); #1;
    check("abort_idle_flush", 32'(bus.flush), 32'd0);
    check("abort_idle_done", 32'(bus.mc_done), 32'd0);
    check("abort_idle_busy", 32'(bus.mc_busy), 32'd0);

    // Priority: flush beats mc start and load-use
    step();
    bus.flush_req = 1'b1; bus.ex_mc_start = 1'b1;
    set_load(5'd4, 1'b1, 5'd4, 1'b0, 5'd0); #1;
    check("prio_stall", 32'(bus.stall), 32'(S_NONE));
    check("prio_busy", 32'(bus.mc_busy), 32'd0);
    step(); bus.flush_req = 1'b1; set_load(5'd4, 1'b1, 5'd4, 1'b0, 5'd0); #1;
    check("prio_flush", 32'(bus.flush), 32'd1);
    check("prio_flush_busy", 32'(bus.mc_busy), 32'd0);
    check("prio_flush_stall", 32'(bus.stall), 32'(S_NONE));
    step(); bus.flush_req = 1'b1; #1;
    check("b2b_idle_flush", 32'(bus.flush), 32'd0);
    step(); #1;
    check("b2b_flush_again", 32'(bus.flush), 32'd1);
    step(); #1;
    check("b2b_done_flush", 32'(bus.flush), 32'd0);

    // Async reset mid-op at cnt=17
    step(); bus.ex_mc_start = 1'b1;
    for (int k = 1; k <= 15; k++) step();
    #1;
    check("prerst_stall", 32'(bus.stall), 32'(S_EX));
    bus.ex_mc_start = 1'b1;
    rst = 1'b0;
    #1;
    check("arst_stall", 32'(bus.stall), 32'(S_NONE));
    check("arst_busy", 32'(bus.mc_busy), 32'd0);
    check("arst_done", 32'(bus.mc_done), 32'd0);
    check("arst_flush", 32'(bus.flush), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    check("postrst_stall", 32'(bus.stall), 32'(S_NONE));
    check("postrst_busy", 32'(bus.mc_busy), 32'd0);
    step(); #1;
    check("postrst_done", 32'(bus.mc_done), 32'd0);
    mc_op("mc2", 1'b0);

`ifdef STALL_CTRL_PERF_EN
    begin
      logic [31:0] s0, l0;
      s0 = bus.perf_stall;
      l0 = bus.perf_load_use;
      step(); set_load(5'd6, 1'b1, 5'd6, 1'b0, 5'd0);
      step(); bus.id_stallreq = 1'b1;
      step(); set_load(5'd8, 1'b0, 5'd0, 1'b1, 5'd8);
      mc_op("perf_mc", 1'b0);
      check("perf_stall_delta", bus.perf_stall - s0, 32'(3 + LAT));
      check("perf_lu_delta", bus.perf_load_use - l0, 32'd2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
